// File: rtl/umi_messages.sv
`default_nettype none
// ============================================================================
// Module  : umi_messages (package)
// Purpose : Shared UMI message definitions: atomic operation codes, the
//           memory-agent state encoding and a helper to spot supported atypes.
// Revision: 1.0 - initial release
// ============================================================================
package umi_messages;

  // Atomic operation codes
  localparam logic [7:0] c_atype_add  = 8'h00;
  localparam logic [7:0] c_atype_and  = 8'h01;
  localparam logic [7:0] c_atype_or   = 8'h02;
  localparam logic [7:0] c_atype_xor  = 8'h03;
  localparam logic [7:0] c_atype_max  = 8'h04;
  localparam logic [7:0] c_atype_min  = 8'h05;
  localparam logic [7:0] c_atype_maxu = 8'h06;
  localparam logic [7:0] c_atype_minu = 8'h07;
  localparam logic [7:0] c_atype_swap = 8'h08;

  // Memory agent control states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } agent_state_t;

  // Codes are dense from ADD to SWAP, so a single bound covers them all.
  function automatic logic atype_supported(input logic [7:0] atype);
    return (atype <= c_atype_swap);
  endfunction

endpackage
`default_nettype wire

// File: rtl/umi_atomic_alu.sv
`default_nettype none
// ============================================================================
// Module  : umi_atomic_alu
// Purpose : Combinational atomic ALU for elements of 1, 2, 4 or 8 bytes.
// Ports   : i_old_op  [63:0] value currently in memory (element in low bytes)
//           i_new_op  [63:0] operand carried by the request
//           i_atype   [7:0]  operation code
//           i_size    [2:0]  log2 of element size in bytes (0..3)
//           o_result  [63:0] result; only the low 2^size bytes are meaningful
// Revision: 1.0 - initial release
// ============================================================================
module umi_atomic_alu
  import umi_messages::*;
(
  input  logic [63:0] i_old_op,
  input  logic [63:0] i_new_op,
  input  logic [7:0]  i_atype,
  input  logic [2:0]  i_size,
  output logic [63:0] o_result
);

  logic [5:0]  w_shamt;
  logic [63:0] w_old_al;
  logic [63:0] w_new_al;
  logic        w_gt_s;
  logic        w_lt_s;
  logic        w_gt_u;
  logic        w_lt_u;

  // Left-justify both elements so the element's sign bit lands in bit 63;
  // one 64-bit signed/unsigned comparator then serves every size.
  always_comb begin
    w_shamt = 6'd0;
    case (i_size)
      3'd0:    w_shamt = 6'd56;
      3'd1:    w_shamt = 6'd48;
      3'd2:    w_shamt = 6'd32;
      default: w_shamt = 6'd0;
    endcase
  end

  assign w_old_al = i_old_op << w_shamt;
  assign w_new_al = i_new_op << w_shamt;
  assign w_gt_s   = $signed(w_old_al) > $signed(w_new_al);
  assign w_lt_s   = $signed(w_old_al) < $signed(w_new_al);
  assign w_gt_u   = w_old_al > w_new_al;
  assign w_lt_u   = w_old_al < w_new_al;

  // ADD wraps naturally: carries above the element are never written back.
  always_comb begin
    o_result = i_old_op;
    case (i_atype)
      c_atype_add:  o_result = i_old_op + i_new_op;
      c_atype_and:  o_result = i_old_op & i_new_op;
      c_atype_or:   o_result = i_old_op | i_new_op;
      c_atype_xor:  o_result = i_old_op ^ i_new_op;
      c_atype_max:  o_result = w_gt_s ? i_old_op : i_new_op;
      c_atype_min:  o_result = w_lt_s ? i_old_op : i_new_op;
      c_atype_maxu: o_result = w_gt_u ? i_old_op : i_new_op;
      c_atype_minu: o_result = w_lt_u ? i_old_op : i_new_op;
      c_atype_swap: o_result = i_new_op;
      default:      o_result = i_old_op;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/umi_mem_agent.sv
`default_nettype none
// ============================================================================
// Module  : umi_mem_agent
// Purpose : Single-port memory agent with byte-granular writes, 1-cycle
//           registered reads and two-cycle atomic read-modify-write.
// Ports   : clk, reset (async, active-high)
//           loc_addr/loc_write/loc_read/loc_atomic/loc_atype/loc_size/
//           loc_len/loc_wrdata : request inputs (one op per cycle)
//           loc_rddata         : registered read data (full row)
//           loc_ready          : request can be accepted this cycle
// Revision: 1.0 - initial release
// ============================================================================
module umi_mem_agent
  import umi_messages::*;
#(
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] loc_addr,
  input  logic          loc_write,
  input  logic          loc_read,
  input  logic          loc_atomic,
  input  logic [7:0]    loc_atype,
  input  logic [2:0]    loc_size,
  input  logic [7:0]    loc_len,
  input  logic [DW-1:0] loc_wrdata,
  output logic [DW-1:0] loc_rddata,
  output logic          loc_ready
);

  localparam int c_nb = DW / 8;
  localparam int c_ob = $clog2(c_nb);
  localparam int c_rb = $clog2(DEPTH);

  // Pull an 8-byte element starting at byte 'off' out of a row; bytes that
  // would fall past the row end read as zero.
  function automatic logic [63:0] lane_get(input logic [DW-1:0] row,
                                           input logic [c_ob-1:0] off);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      if (int'(off) + b < c_nb) v[b*8 +: 8] = row[(int'(off) + b)*8 +: 8];
    end
    return v;
  endfunction

  logic [DW-1:0]  r_mem [DEPTH];
  agent_state_t   r_state;
  agent_state_t   w_state_nxt;
  logic [c_rb-1:0] r_row;
  logic [c_ob-1:0] r_off;
  logic [2:0]     r_size;
  logic [7:0]     r_atype;
  logic [63:0]    r_opnd;
  logic [DW-1:0]  r_rddata;

  logic [c_rb-1:0] w_row_in;
  logic [c_ob-1:0] w_off_in;
  logic           w_single;
  logic           w_idle;
  logic           w_acc;
  logic           w_acc_rd;
  logic           w_acc_wr;
  logic           w_acc_amo;
  logic           w_in_rmw;
  logic [63:0]    w_opnd_new;
  logic [63:0]    w_opnd_old;
  logic [63:0]    w_result;
  logic [DW-1:0]  w_res_row;
  logic [c_rb-1:0] w_wr_row;
  logic [c_ob-1:0] w_wr_off;
  logic [16:0]    w_wr_nbytes;
  logic [17:0]    w_wr_end;
  logic [DW-1:0]  w_wdata;
  logic [c_nb-1:0] w_be;
  logic           w_we;
  logic           w_unused;

  // Upper address bits are deliberately ignored (addresses wrap).
  assign w_unused = ^loc_addr;

  assign w_row_in = loc_addr[c_ob+c_rb-1:c_ob];
  assign w_off_in = loc_addr[c_ob-1:0];

  // Exactly one request type must be set; anything else is dropped.
  assign w_single  = ({loc_read, loc_write, loc_atomic} == 3'b100) ||
                     ({loc_read, loc_write, loc_atomic} == 3'b010) ||
                     ({loc_read, loc_write, loc_atomic} == 3'b001);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_acc     = w_idle && w_single;
  // Unsupported atomics degrade to plain reads, so every atomic reads.
  assign w_acc_rd  = w_acc && (loc_read || loc_atomic);
  assign w_acc_wr  = w_acc && loc_write;
  assign w_acc_amo = w_acc && loc_atomic && (loc_size <= 3'd3) &&
                     atype_supported(loc_atype);

  // Control FSM
  always_comb begin
    w_state_nxt = r_state;
    loc_ready   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_amo) w_state_nxt = ST_RMW;
      end
      ST_RMW: begin
        loc_ready   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Atomic datapath: the stored element is fetched during the RMW cycle
  assign w_opnd_new = lane_get(loc_wrdata, w_off_in);
  assign w_opnd_old = lane_get(r_mem[r_row], r_off);

  umi_atomic_alu u_alu (
    .i_old_op (w_opnd_old),
    .i_new_op (r_opnd),
    .i_atype  (r_atype),
    .i_size   (r_size),
    .o_result (w_result)
  );

  assign w_res_row = DW'(w_result) << {r_off, 3'b000};

  // Shared write port: RMW result or direct write. Lengths are clipped at
  // the row end by the byte-enable compare, never wrapped.
  assign w_in_rmw    = (r_state == ST_RMW);
  assign w_wr_row    = w_in_rmw ? r_row : w_row_in;
  assign w_wr_off    = w_in_rmw ? r_off : w_off_in;
  assign w_wr_nbytes = w_in_rmw ? (17'd1 << r_size)
                                : ((17'(loc_len) + 17'd1) << loc_size);
  assign w_wr_end    = 18'(w_wr_off) + 18'(w_wr_nbytes);
  assign w_wdata     = w_in_rmw ? w_res_row : loc_wrdata;
  assign w_we        = !reset && (w_in_rmw || w_acc_wr);

  always_comb begin
    w_be = '0;
    for (int i = 0; i < c_nb; i++) begin
      w_be[i] = (18'(i) >= 18'(w_wr_off)) && (18'(i) < w_wr_end);
    end
  end

  // Storage has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < c_nb; i++) begin
        if (w_be[i]) r_mem[w_wr_row][i*8 +: 8] <= w_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rddata <= '0;
      r_row    <= '0;
      r_off    <= '0;
      r_size   <= '0;
      r_atype  <= '0;
      r_opnd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc_rd) r_rddata <= r_mem[w_row_in];
      if (w_acc_amo) begin
        r_row   <= w_row_in;
        r_off   <= w_off_in;
        r_size  <= loc_size;
        r_atype <= loc_atype;
        r_opnd  <= w_opnd_new;
      end
    end
  end

  assign loc_rddata = r_rddata;

endmodule
`default_nettype wire

// File: tb/tb_umi_mem_agent.sv
`default_nettype none
// ============================================================================
// Module  : tb_umi_mem_agent
// Purpose : Self-checking bench for umi_mem_agent (default parameters) with a
//           reference memory model and an expected-read-data queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_umi_mem_agent;

  localparam int c_dw = 256;
  localparam int c_nb = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [63:0]    loc_addr = '0;
  logic           loc_write = 1'b0;
  logic           loc_read = 1'b0;
  logic           loc_atomic = 1'b0;
  logic [7:0]     loc_atype = '0;
  logic [2:0]     loc_size = '0;
  logic [7:0]     loc_len = '0;
  logic [c_dw-1:0] loc_wrdata = '0;
  logic [c_dw-1:0] loc_rddata;
  logic           loc_ready;

  logic [c_dw-1:0] m_mem [256];
  logic [c_dw-1:0] exp_q [$];
  int             n_vec = 0;
  int             n_err = 0;

  umi_mem_agent u_dut (
    .clk        (clk),
    .reset      (reset),
    .loc_addr   (loc_addr),
    .loc_write  (loc_write),
    .loc_read   (loc_read),
    .loc_atomic (loc_atomic),
    .loc_atype  (loc_atype),
    .loc_size   (loc_size),
    .loc_len    (loc_len),
    .loc_wrdata (loc_wrdata),
    .loc_rddata (loc_rddata),
    .loc_ready  (loc_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [c_dw-1:0] act,
                       input logic [c_dw-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One request for exactly one clock; returns 1ns after the accepting edge.
  task automatic drive(input logic rd, input logic wr, input logic am,
                       input logic [63:0] addr, input logic [2:0] size,
                       input logic [7:0] len, input logic [7:0] atype,
                       input logic [c_dw-1:0] data);
    @(negedge clk);
    loc_read = rd; loc_write = wr; loc_atomic = am;
    loc_addr = addr; loc_size = size; loc_len = len;
    loc_atype = atype; loc_wrdata = data;
    @(posedge clk);
    #1;
    loc_read = 1'b0; loc_write = 1'b0; loc_atomic = 1'b0;
  endtask

  task automatic m_put(input int row, input int off, input int n,
                       input logic [c_dw-1:0] data);
    for (int b = 0; b < c_nb; b++)
      if (b >= off && b < off + n) m_mem[row][b*8 +: 8] = data[b*8 +: 8];
  endtask

  function automatic logic [63:0] amo_model(input logic [7:0] t,
                                            input logic [2:0] sz,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    int          nb;
    logic [63:0] mask, ua, ub, r;
    longint      sa, sb;
    nb   = 1 << sz;
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 64'd1);
    ua   = a & mask;
    ub   = b & mask;
    sa   = a[8*nb-1] ? longint'(a | ~mask) : longint'(ua);
    sb   = b[8*nb-1] ? longint'(b | ~mask) : longint'(ub);
    case (t)
      8'h00: r = a + b;
      8'h01: r = a & b;
      8'h02: r = a | b;
      8'h03: r = a ^ b;
      8'h04: r = (sa > sb) ? a : b;
      8'h05: r = (sa < sb) ? a : b;
      8'h06: r = (ua > ub) ? a : b;
      8'h07: r = (ua < ub) ? a : b;
      8'h08: r = b;
      default: r = a;
    endcase
    return r & mask;
  endfunction

  task automatic do_write(input logic [63:0] addr, input logic [2:0] size,
                          input logic [7:0] len, input logic [c_dw-1:0] data);
    m_put(int'(addr[12:5]), int'(addr[4:0]), (int'(len) + 1) << size, data);
    drive(1'b0, 1'b1, 1'b0, addr, size, len, 8'h00, data);
  endtask

  task automatic do_read(input logic [63:0] addr);
    exp_q.push_back(m_mem[addr[12:5]]);
    drive(1'b1, 1'b0, 1'b0, addr, 3'd0, 8'd0, 8'h00, '0);
    check("read", loc_rddata, exp_q.pop_front());
  endtask

  task automatic do_amo(input logic [63:0] addr, input logic [7:0] atype,
                        input logic [2:0] size, input logic [63:0] opnd);
    int              row, off;
    logic            ok;
    logic [c_dw-1:0] tmp, data;
    logic [63:0]     old, res;
    row  = int'(addr[12:5]);
    off  = int'(addr[4:0]);
    ok   = (size <= 3'd3) && (atype <= 8'h08);
    tmp  = m_mem[row] >> (off*8);
    old  = tmp[63:0];
    data = c_dw'(opnd) << (off*8);
    exp_q.push_back(m_mem[row]);
    drive(1'b0, 1'b0, 1'b1, addr, size, 8'hFF, atype, data);
    check("amo_old", loc_rddata, exp_q.pop_front());
    if (ok) begin
      check("amo_busy", c_dw'(loc_ready), c_dw'(1'b0));
      res = amo_model(atype, size, old, opnd);
      m_put(row, off, 1 << size, c_dw'(res) << (off*8));
      @(posedge clk);
      #1;
    end
    check("amo_ready", c_dw'(loc_ready), c_dw'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [c_dw-1:0] prev;
    logic [c_dw-1:0] rnd;
    int              off;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", c_dw'(loc_ready), c_dw'(1'b1));
    check("rst_rddata", loc_rddata, '0);
    @(negedge clk);
    reset = 1'b0;

    // Seed the rows used below with known contents
    foreach (m_mem[i]) m_mem[i] = '0;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      do_write(64'(r*32), 3'd5, 8'd0, rnd);
    end
    for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
    do_write(64'(255*32), 3'd5, 8'd0, rnd);
    do_read(64'd0);
    do_read(64'(255*32));

    // 4-byte write at byte 4, read back the very next cycle
    do_write(64'h4, 3'd2, 8'd0, c_dw'(32'hAABB_CCDD) << 32);
    do_read(64'h0);
    check("w32_lane", c_dw'(loc_rddata[63:32]), c_dw'(32'hAABB_CCDD));

    // Writes leave read data untouched
    prev = loc_rddata;
    for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
    do_write(64'd32, 3'd5, 8'd0, rnd);
    check("rd_hold", loc_rddata, prev);
    do_read(64'd32);

    // 8 bytes at offset 28: only 4 land, nothing spills into the next row
    do_write(64'(2*32 + 28), 3'd0, 8'd7, '1);
    do_read(64'(2*32));
    do_read(64'(3*32));

    // ADD with wrap: 0x10 + (-8) = 0x8
    do_write(64'h0, 3'd3, 8'd0, c_dw'(64'h10));
    do_amo(64'h0, 8'h00, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8);
    do_read(64'h0);
    check("add_wrap", c_dw'(loc_rddata[63:0]), c_dw'(64'h8));

    // Signed vs unsigned max on a byte
    do_write(64'h1, 3'd0, 8'd0, c_dw'(8'h80) << 8);
    do_amo(64'h1, 8'h04, 3'd0, 64'h01);
    do_read(64'h0);
    check("max_s", c_dw'(loc_rddata[15:8]), c_dw'(8'h01));
    do_write(64'h1, 3'd0, 8'd0, c_dw'(8'h80) << 8);
    do_amo(64'h1, 8'h06, 3'd0, 64'h01);
    do_read(64'h0);
    check("max_u", c_dw'(loc_rddata[15:8]), c_dw'(8'h80));

    // Every op at every size, naturally aligned within row 1
    for (int t = 0; t < 9; t++) begin
      for (int sz = 0; sz < 4; sz++) begin
        off = int'($urandom_range(0, 31)) & ~((1 << sz) - 1);
        do_amo(64'(32 + off), 8'(t), 3'(sz), {$urandom, $urandom});
        do_read(64'd32);
      end
    end

    // Unknown atype and oversize atomics act as plain reads
    do_amo(64'h8, 8'h09, 3'd2, 64'h1234_5678);
    do_read(64'h0);
    do_amo(64'h0, 8'h00, 3'd4, 64'h1);
    do_read(64'h0);

    // Reset during the RMW cycle of a SWAP aborts the write
    drive(1'b0, 1'b0, 1'b1, 64'(2*32 + 8), 3'd3, 8'd0, 8'h08,
          c_dw'(64'hDEAD_BEEF_0000_0001) << 64);
    check("swap_busy", c_dw'(loc_ready), c_dw'(1'b0));
    reset = 1'b1;
    #1;
    check("abort_ready", c_dw'(loc_ready), c_dw'(1'b1));
    check("abort_rddata", loc_rddata, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_read(64'(2*32));

    // Address aliasing: DEPTH*DW/8 maps back to row 0
    do_write(64'd8192 + 64'd16, 3'd2, 8'd0, c_dw'(32'h1234_5678) << 128);
    do_read(64'h0);
    check("alias", c_dw'(loc_rddata[159:128]), c_dw'(32'h1234_5678));

    // Multi-type requests are ignored entirely
    prev = loc_rddata;
    drive(1'b1, 1'b1, 1'b0, 64'h0, 3'd5, 8'd0, 8'h00, '1);
    check("dual_hold", loc_rddata, prev);
    drive(1'b1, 1'b1, 1'b1, 64'h0, 3'd3, 8'd0, 8'h08, '1);
    check("triple_ready", c_dw'(loc_ready), c_dw'(1'b1));
    do_read(64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/umi_mem_agent.md
UMI_MEM_AGENT -- requirements
Module: umi_mem_agent

Interface
REQ-001 Parameters SHALL be: DW, default 256, data/row width in bits (power of 2, >=64).
REQ-002 Parameters SHALL be: AW, default 64, address width.
REQ-003 Parameters SHALL be: DEPTH, default 256, number of DW-bit rows (power of 2).
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- loc_addr  in  AW  byte address.
- loc_write  in  1  write request.
- loc_read  in  1  read request.
- loc_atomic  in  1  atomic read-modify-write request.
- loc_atype  in  8  atomic operation code.
- loc_size  in  3  log2 of the element size in bytes.
- loc_len  in  8  element count minus 1.
- loc_wrdata  in  DW  write data, byte-lane aligned.
- loc_rddata  out  DW  read data, registered.
- loc_ready  out  1  agent can accept a request this cycle.
REQ-005 The agent SHALL accept a request in any cycle where loc_ready=1 and exactly one of loc_read, loc_write or loc_atomic is 1; requests with zero or multiple of these set SHALL be ignored.

Function
REQ-006 Row index SHALL be loc_addr[log2(DW/8)+log2(DEPTH)-1 : log2(DW/8)]; the upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*DW/8.
REQ-007 Byte offset SHALL be off = loc_addr[log2(DW/8)-1:0]; byte count SHALL be nbytes = (loc_len+1) << loc_size.
REQ-008 Write byte enables SHALL cover bytes off .. min(off+nbytes, DW/8)-1; bytes past the row end SHALL be dropped, with no wrap into the next row.
REQ-009 An accepted write SHALL update the enabled bytes at the rising edge of acceptance; unselected bytes SHALL be unchanged.
REQ-010 An accepted read SHALL drive the full row onto loc_rddata in the next cycle (1-cycle latency).
REQ-011 loc_rddata SHALL hold its value until the next accepted read or atomic; writes SHALL NOT change it.
REQ-012 The FSM SHALL have two states, IDLE and RMW.
- IDLE: loc_ready=1; an accepted atomic SHALL capture row, offset, size, atype and operand, and move to RMW.
- RMW: loc_ready=0; SHALL write the result and return to IDLE after 1 cycle.
REQ-013 For an atomic accepted in cycle T:
- loc_rddata SHALL present the pre-operation row in T+1.
- The result SHALL be written to the selected bytes at the end of T+1.
- loc_ready SHALL be 0 in T+1 and 1 in T+2.
REQ-014 Atomic operands SHALL be 2^loc_size bytes with loc_size<=3; loc_len SHALL be ignored for atomics.
REQ-015 Atomics with loc_size>3 or an unknown atype SHALL behave as a read only: no write, no RMW state.
REQ-016 Atomic ops SHALL be ADD (wraps mod 2^(8*size)), AND, OR, XOR, MAX/MIN (signed), MAXU/MINU (unsigned) and SWAP; the result SHALL replace the operand bytes.
REQ-017 A read accepted immediately after a write to the same row SHALL return the written data (no stale data).

Reset
REQ-018 While reset=1, state SHALL be IDLE, loc_rddata SHALL be 0 and loc_ready SHALL be 1; memory contents SHALL NOT be reset.
REQ-019 Reset asserted in RMW SHALL abort the pending write; the row SHALL keep its pre-atomic value.

Structure
REQ-020 Atype codes SHALL be defined in the shared umi_messages package: ADD=0x00, AND=0x01, OR=0x02, XOR=0x03, MAX=0x04, MIN=0x05, MAXU=0x06, MINU=0x07, SWAP=0x08.
REQ-021 Atomic ALU arithmetic SHALL be a combinational sub-module, umi_atomic_alu (inputs: old operand, new operand, atype, size; output: result).
REQ-022 Storage SHALL be a flop/RAM array with byte write enables.

Verification
REQ-023 Write 0xAABBCCDD, size=2, len=0, addr 0x4; then read row 0 -> loc_rddata[63:32]=0xAABBCCDD, all other bytes unchanged, returned 1 cycle after acceptance.
REQ-024 Write size=0, len=7 at off=DW/8-4 -> only the top 4 bytes of the row change; the next row is unchanged.
REQ-025 Memory holds 0x10 at addr 0x0; ATOMIC ADD, size=3, operand 0xFFFFFFFFFFFFFFF8 -> T+1 loc_rddata[63:0]=0x10, loc_ready=0 in T+1; later read returns 0x8.
REQ-026 MAX vs MAXU with stored 0x80 and operand 0x01, size=0 -> stored results 0x01 and 0x80 respectively.
REQ-027 Assert reset in the RMW cycle of a SWAP -> row unchanged, loc_ready=1 and loc_rddata=0 after reset.
REQ-028 Address 0x0 vs (DEPTH*DW/8); read/write with loc_read and loc_write both 1 -> aliasing to row 0 for the first; the dual request is ignored and memory unchanged.
